// File: rtl/demux_1ne2.sv
// Registered 1-to-2 demultiplexer with per-channel one-entry holding registers and
// valid/ready handshakes. Define DEMUX_STATS_EN to add per-channel delivery counters.
module demux_1ne2 #(
  parameter int unsigned W = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [W-1:0] Hyrja,
  input  logic         S,
  input  logic         Valid_in,
  output logic         Ready_in,
  output logic [W-1:0] Dalja0,
  output logic         Valid0,
  input  logic         Ready0,
  output logic [W-1:0] Dalja1,
  output logic         Valid1,
  input  logic         Ready1
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]  Count0,
  output logic [15:0]  Count1
`endif
);

  typedef enum logic {StEmpty, StFull} ch_state_e;

  ch_state_e        state0_q, state0_d;
  ch_state_e        state1_q, state1_d;
  logic [W-1:0]     data0_q, data0_d;
  logic [W-1:0]     data1_q, data1_d;
  logic             accept;
  logic             accept0, accept1;
  logic             drain0, drain1;

  // Only the selected channel may stall the input.
  always_comb begin
    Ready_in = 1'b0;
    if (S) begin
      Ready_in = (state1_q == StEmpty) || Ready1;
    end else begin
      Ready_in = (state0_q == StEmpty) || Ready0;
    end
  end

  assign accept  = Valid_in && Ready_in;
  assign accept0 = accept && !S;
  assign accept1 = accept && S;
  assign drain0  = (state0_q == StFull) && Ready0;
  assign drain1  = (state1_q == StFull) && Ready1;

  always_comb begin
    state0_d = state0_q;
    data0_d  = data0_q;
    if (accept0) begin
      state0_d = StFull;
      data0_d  = Hyrja;
    end else if (drain0) begin
      state0_d = StEmpty;
    end
  end

  always_comb begin
    state1_d = state1_q;
    data1_d  = data1_q;
    if (accept1) begin
      state1_d = StFull;
      data1_d  = Hyrja;
    end else if (drain1) begin
      state1_d = StEmpty;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state0_q <= StEmpty;
      state1_q <= StEmpty;
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      state0_q <= state0_d;
      state1_q <= state1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
    end
  end

  assign Dalja0 = data0_q;
  assign Dalja1 = data1_q;
  assign Valid0 = (state0_q == StFull);
  assign Valid1 = (state1_q == StFull);

`ifdef DEMUX_STATS_EN
  logic [15:0] count0_q, count0_d;
  logic [15:0] count1_q, count1_d;

  // Counters wrap naturally at 16 bits.
  always_comb begin
    count0_d = count0_q;
    count1_d = count1_q;
    if (drain0) count0_d = count0_q + 16'd1;
    if (drain1) count1_d = count1_q + 16'd1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      count0_q <= count0_d;
      count1_q <= count1_d;
    end
  end

  assign Count0 = count0_q;
  assign Count1 = count1_q;
`endif

endmodule
